// File: rtl/verbus_arbiter.sv
// verbus_arbiter: round-robin arbiter sharing one slave bus between two requesters.
// Define VERBUS_ARBITER_TIMEOUT_EN to add a slave-timeout watchdog that force-completes stalled transfers.
module verbus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_address,
  input  logic [3:0]  m0_wstrobe,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_address,
  input  logic [3:0]  m1_wstrobe,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_address,
  output logic [3:0]  s_wstrobe,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        timeout_error
);
  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_t;
  state_t state, state_nx;
  logic last_m1, last_m1_nx;
  logic busy0, busy1, cur_valid, timeout_hit;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end
  assign busy0     = state == BUSY_M0;
  assign busy1     = state == BUSY_M1;
  assign cur_valid = busy0 ? m0_valid : busy1 & m1_valid;
`ifdef VERBUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       timeout_q;
  assign timeout_hit   = (busy0 | busy1) & ~s_ready & (wait_cnt == WAIT_MAX);
  assign timeout_error = timeout_q;
  // Counter is zero whenever IDLE, so every grant starts a fresh wait window
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt  <= ((busy0 | busy1) & ~s_ready & ~timeout_hit) ? wait_cnt + 8'd1 : 8'd0;
      timeout_q <= timeout_q | timeout_hit;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign timeout_error = 1'b0;
`endif
  always_comb begin
    state_nx   = state;
    last_m1_nx = last_m1;
    if (state == IDLE)
      state_nx = (m0_valid & (~m1_valid | last_m1)) ? BUSY_M0 : m1_valid ? BUSY_M1 : IDLE;
    else if (s_ready | timeout_hit) begin
      state_nx   = IDLE;
      last_m1_nx = busy1;
    end else if (!cur_valid)
      state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_nx;
      last_m1 <= last_m1_nx;
    end
  end
  // A forced completion hides the cycle from the slave and returns zero data
  assign s_valid   = cur_valid & ~timeout_hit;
  assign s_address = busy0 ? m0_address : busy1 ? m1_address : '0;
  assign s_wstrobe = busy0 ? m0_wstrobe : busy1 ? m1_wstrobe : '0;
  assign s_wdata   = busy0 ? m0_wdata : busy1 ? m1_wdata : '0;
  assign m0_ready  = busy0 & (s_ready | timeout_hit);
  assign m1_ready  = busy1 & (s_ready | timeout_hit);
  assign m0_rdata  = (busy0 & ~timeout_hit) ? s_rdata : '0;
  assign m1_rdata  = (busy1 & ~timeout_hit) ? s_rdata : '0;
endmodule

// File: tb/tb_verbus_arbiter.sv
// tb_verbus_arbiter: directed vector table plus corner-case sequences for verbus_arbiter.
module tb_verbus_arbiter;
  logic        clk, reset;
  logic        m0_valid, m0_ready, m1_valid, m1_ready, s_valid, s_ready, timeout_error;
  logic [31:0] m0_address, m0_wdata, m0_rdata, m1_address, m1_wdata, m1_rdata;
  logic [31:0] s_address, s_wdata, s_rdata;
  logic [3:0]  m0_wstrobe, m1_wstrobe, s_wstrobe;
  logic [159:0] bus;
  int passed = 0, total = 0;

  localparam logic [31:0] A0 = 32'h0000_0040, A1 = 32'h0000_0100;
  localparam logic [31:0] D0 = 32'hA0A0_A0A0, D1 = 32'hDEAD_BEEF, RD = 32'h1234_5678;

  verbus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_address(m0_address), .m0_wstrobe(m0_wstrobe), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_address(m1_address), .m1_wstrobe(m1_wstrobe), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_address(s_address), .s_wstrobe(s_wstrobe), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .timeout_error(timeout_error)
  );

  assign bus = {24'd0, m0_ready, m1_ready, s_valid, s_address, s_wstrobe, s_wdata, m0_rdata, m1_rdata, timeout_error};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // g: expected grant visible this cycle (0 none, 1 m0, 2 m1)
  typedef struct packed {
    logic m0v, m1v, sr;
    logic [1:0] g;
    logic m0r, m1r, sv;
  } vec_t;
  vec_t vecs[14];

  function automatic logic [159:0] expect_bus(input vec_t v);
    logic [31:0] a, d;
    logic [3:0]  w;
    a = v.g == 2'd1 ? A0 : v.g == 2'd2 ? A1 : 32'd0;
    w = v.g == 2'd2 ? 4'hF : 4'h0;
    d = v.g == 2'd1 ? D0 : v.g == 2'd2 ? D1 : 32'd0;
    return {24'd0, v.m0r, v.m1r, v.sv, a, w, d, v.g == 2'd1 ? RD : 32'd0, v.g == 2'd2 ? RD : 32'd0, 1'b0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic do_reset;
    reset = 1; m0_valid = 0; m1_valid = 0; s_ready = 0;
    tick;
    reset = 0;
  endtask

  initial begin
    logic [11:0] ord;
    logic both, stable, m0p, bad;
    int m1p;
    m0_address = A0; m0_wstrobe = 4'h0; m0_wdata = D0;
    m1_address = A1; m1_wstrobe = 4'hF; m1_wdata = D1;
    s_rdata = RD;
    vecs = '{
      9'b110_00_000, 9'b111_01_101, 9'b110_00_000, 9'b111_10_011,
      9'b110_00_000, 9'b110_01_001, 9'b111_01_101, 9'b000_00_000,
      9'b010_00_000, 9'b011_10_011, 9'b100_00_000, 9'b000_01_000,
      9'b110_00_000, 9'b111_01_101};
    do_reset;
    #1 chk("reset_idle", bus, 160'd0);
    for (int i = 0; i < 14; i++) begin
      {m0_valid, m1_valid, s_ready} = {vecs[i].m0v, vecs[i].m1v, vecs[i].sr};
      #1 chk($sformatf("vec%0d", i), bus, expect_bus(vecs[i]));
      tick;
    end

    // both requesters always valid, zero-wait slave
    do_reset;
    m0_valid = 1; m1_valid = 1; s_ready = 1; ord = 0; both = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      both |= m0_ready & m1_ready;
      if (m0_ready) ord = {ord[9:0], 2'd1};
      if (m1_ready) ord = {ord[9:0], 2'd2};
      tick;
    end
    chk("rr_order", ord, 12'b01_10_01_10_01_10);
    chk("rr_no_double", both, 0);

    // m1 write with a 3-cycle wait slave
    do_reset;
    m1_valid = 1; stable = 1; m0p = 0; m1p = 0;
    tick;
    for (int k = 0; k < 4; k++) begin
      s_ready = (k == 3);
      #1;
      stable &= (s_wdata == D1) && (s_wstrobe == 4'hF) && s_valid;
      m1p += int'(m1_ready);
      m0p |= m0_ready;
      tick;
    end
    m1_valid = 0; s_ready = 0;
    chk("wait_wdata_stable", stable, 1);
    chk("wait_m1_single_pulse", m1p, 1);
    chk("wait_m0_quiet", m0p, 0);
    #1 chk("wait_back_idle", {s_valid, m1_ready}, 0);
    tick;

    // reset mid-transaction after m0 last won
    do_reset;
    m0_valid = 1;
    tick;
    s_ready = 1;
    #1 chk("rst_pre_m0_done", m0_ready, 1);
    tick;
    s_ready = 0;
    tick;
    #1 chk("rst_busy_m0", {s_valid, s_address}, {1'b1, A0});
    reset = 1;
    #1 chk("rst_no_ready", {m0_ready, m1_ready}, 0);
    tick;
    reset = 0; m1_valid = 1;
    #1 chk("rst_idle_after", {m0_ready, m1_ready, s_valid, s_address}, 0);
    tick;
    #1 chk("rst_m0_wins", {s_valid, s_address}, {1'b1, A0});
    m0_valid = 0; m1_valid = 0;
    tick;

    // stalled slave
    do_reset;
    m0_valid = 1; s_ready = 0;
    tick;
`ifdef VERBUS_ARBITER_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k < 3) chk($sformatf("to_wait%0d", k), {m0_ready, s_valid, timeout_error}, 3'b010);
      else chk("to_force", {m0_ready, s_valid, m0_rdata}, {2'b10, 32'd0});
      tick;
    end
    m0_valid = 0;
    #1 chk("to_flag_set", {timeout_error, s_valid}, 2'b10);
    for (int k = 0; k < 5; k++) tick;
    #1 chk("to_flag_sticky", timeout_error, 1);
    do_reset;
    #1 chk("to_flag_cleared", timeout_error, 0);
`else
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      #1 bad |= m0_ready | ~s_valid | timeout_error | (s_address != A0);
      tick;
    end
    chk("no_to_stays_busy", bad, 0);
    #1 chk("no_to_flag", timeout_error, 0);
    do_reset;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
